// File: rtl/code_verify_engine_if.sv
// Request/result bundle between the code entry path and the verify engine.
// master drives the request side, slave (the engine) drives the result side.
interface code_verify_engine_if #(
    parameter int DIGITS   = 4,
    parameter int DIGIT_W  = 4,
    parameter int MAX_FAIL = 3
);
    localparam int FW = $clog2(MAX_FAIL + 1);

    logic                        req;
    logic [DIGITS*DIGIT_W-1:0]   input_code;
    logic [DIGITS*DIGIT_W-1:0]   stored_code;
    logic                        clr_lock;
    logic                        ready;
    logic                        done;
    logic                        match;
    logic                        locked;
    logic [FW-1:0]               fail_count;

    modport master (
        output req, input_code, stored_code, clr_lock,
        input  ready, done, match, locked, fail_count
    );

    modport slave (
        input  req, input_code, stored_code, clr_lock,
        output ready, done, match, locked, fail_count
    );
endinterface

// File: rtl/code_verify_engine.sv
// Constant-time passcode comparator: one digit per cycle, MSB digit first,
// with consecutive-failure counting and a timed lockout.
module code_verify_engine #(
    parameter int DIGITS      = 4,
    parameter int DIGIT_W     = 4,
    parameter int SCRAMBLE    = 1,
    parameter int MAX_FAIL    = 3,
    parameter int LOCK_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    code_verify_engine_if.slave   bus
);
    localparam int FW = $clog2(MAX_FAIL + 1);
    localparam int LW = $clog2(LOCK_CYCLES + 1);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {IDLE, COMPARE, LOCKED} state_t;

    state_t                          state;
    logic [DIGITS-1:0][DIGIT_W-1:0]  in_q, st_q, st_plain;
    logic [IW-1:0]                   idx;
    logic                            acc, acc_next, clr_seen;
    logic                            ready_q, done_q, match_q, locked_q;
    logic [FW-1:0]                   fail_q;
    logic [LW-1:0]                   lock_cnt;

    // Undo the slot scramble: top digit lives in slot 1, the middle digits
    // are shifted up one slot, d0 stays put.
    for (genvar g = 0; g < DIGITS; g++) begin : g_map
        localparam int SRC = (SCRAMBLE == 0 || g == 0) ? g :
                             (g == DIGITS - 1)         ? 1 : g + 1;
        assign st_plain[g] = bus.stored_code[SRC*DIGIT_W +: DIGIT_W];
    end

    assign acc_next = acc | (in_q[idx] != st_q[idx]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            in_q     <= '0;
            st_q     <= '0;
            idx      <= '0;
            acc      <= 1'b0;
            clr_seen <= 1'b0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            match_q  <= 1'b0;
            locked_q <= 1'b0;
            fail_q   <= '0;
            lock_cnt <= '0;
        end else begin
            done_q  <= 1'b0;
            match_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.clr_lock) fail_q <= '0;
                    if (bus.req) begin
                        in_q     <= bus.input_code;
                        st_q     <= st_plain;
                        idx      <= IW'(DIGITS - 1);
                        acc      <= 1'b0;
                        clr_seen <= 1'b0;
                        ready_q  <= 1'b0;
                        state    <= COMPARE;
                    end
                end
                COMPARE: begin
                    acc <= acc_next;
                    if (bus.clr_lock) clr_seen <= 1'b1;
                    if (idx == '0) begin
                        done_q  <= 1'b1;
                        match_q <= ~acc_next;
                        ready_q <= 1'b1;
                        state   <= IDLE;
                        // An admin clear seen during the compare makes this
                        // result count as zero failures, so it can't lock.
                        if (!acc_next || bus.clr_lock || clr_seen) begin
                            fail_q <= '0;
                        end else if (fail_q == FW'(MAX_FAIL - 1)) begin
                            fail_q   <= FW'(MAX_FAIL);
                            lock_cnt <= LW'(LOCK_CYCLES);
                            locked_q <= 1'b1;
                            ready_q  <= 1'b0;
                            state    <= LOCKED;
                        end else begin
                            fail_q <= fail_q + FW'(1);
                        end
                    end else begin
                        idx <= idx - IW'(1);
                    end
                end
                LOCKED: begin
                    if (bus.clr_lock || lock_cnt <= LW'(1)) begin
                        lock_cnt <= '0;
                        locked_q <= 1'b0;
                        fail_q   <= '0;
                        ready_q  <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        lock_cnt <= lock_cnt - LW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ready      = ready_q;
    assign bus.done       = done_q;
    assign bus.match      = match_q;
    assign bus.locked     = locked_q;
    assign bus.fail_count = fail_q;
endmodule
